// File: rtl/peak_ctrl_pkg.sv
// Shared types for the peak detector sequencer: FSM encoding and event record layout.
package peak_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRST    = 3'd1,
        ST_WARMUP  = 3'd2,
        ST_ARMED   = 3'd3,
        ST_REFRACT = 3'd4
    } state_t;

    localparam int EVT_CNT_W = 16;
    localparam int THR_W     = 16;
    localparam int EVT_W     = EVT_CNT_W + THR_W + 2;

    typedef struct packed {
        logic [EVT_CNT_W-1:0] interval;
        logic [THR_W-1:0]     threshold;
        logic                 timeout;
        logic                 first;
    } evt_t;

    // Event width for a non-default interval counter width.
    function automatic int evt_width(input int cnt_w);
        return cnt_w + THR_W + 2;
    endfunction

endpackage

// File: rtl/peak_evt_fifo.sv
// First-word-fall-through event FIFO: a push is visible at the head one clock later.
// Backpressure: a push into a full FIFO without a pop is dropped and flagged on drop.
module peak_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/peak_detect_ctrl.sv
// Peak detector sequencer: reset/warm-up, refractory gating, interval and timeout events.
// Events reach evt_valid one clock after the peak cycle; a full queue drops and counts.
module peak_detect_ctrl
    import peak_ctrl_pkg::*;
#(
    parameter int WARMUP_SAMPLES = 100,
    parameter int REFRACTORY     = 50,
    parameter int TIMEOUT        = 2000,
    parameter int CNT_W          = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int DET_RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic             peak_in,
    input  logic [15:0]      thr_in,
    output logic             det_rst,
    output logic             busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_interval,
    output logic [15:0]      evt_threshold,
    output logic             evt_timeout,
    output logic             evt_first,
    output logic [7:0]       overflow_cnt,
    output logic [2:0]       state_dbg
);
    localparam int EW = evt_width(CNT_W);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase_cnt, phase_nxt;
    logic [CNT_W-1:0] int_cnt, int_nxt;
    logic             first_q, first_nxt;
    logic             push, push_timeout, flush;
    logic [CNT_W-1:0] push_interval;
    logic [EW-1:0]    push_dat, head_dat;
    logic             fifo_full, fifo_empty, fifo_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            int_cnt      <= '0;
            first_q      <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            int_cnt   <= int_nxt;
            first_q   <= first_nxt;
            if (flush) begin
                overflow_cnt <= '0;
            end else if (fifo_drop && overflow_cnt != 8'hFF) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

    // phase_cnt is shared: DRST clocks, WARMUP strobes, REFRACT strobes.
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase_cnt;
        int_nxt       = int_cnt;
        first_nxt     = first_q;
        push          = 1'b0;
        push_timeout  = 1'b0;
        push_interval = int_cnt;
        flush         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_DRST;
                    phase_nxt = '0;
                    int_nxt   = '0;
                    first_nxt = 1'b1;
                    flush     = 1'b1;
                end
            end
            ST_DRST: begin
                if (phase_cnt == CNT_W'(DET_RST_CYCLES - 1)) begin
                    state_nxt = ST_WARMUP;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + 1'b1;
                end
            end
            ST_WARMUP: begin
                if (sample_valid) begin
                    if (phase_cnt == CNT_W'(WARMUP_SAMPLES - 1)) begin
                        state_nxt = ST_ARMED;
                        int_nxt   = '0;
                    end else begin
                        phase_nxt = phase_cnt + 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (peak_in) begin
                    push      = 1'b1;
                    int_nxt   = '0;
                    first_nxt = 1'b0;
                    state_nxt = ST_REFRACT;
                    phase_nxt = '0;
                end else if (sample_valid) begin
                    if (int_cnt == CNT_W'(TIMEOUT - 1)) begin
                        push          = 1'b1;
                        push_timeout  = 1'b1;
                        push_interval = CNT_W'(TIMEOUT);
                        int_nxt       = '0;
                        first_nxt     = 1'b0;
                    end else begin
                        int_nxt = int_cnt + 1'b1;
                    end
                end
            end
            ST_REFRACT: begin
                if (sample_valid) begin
                    int_nxt = int_cnt + 1'b1;
                    if (phase_cnt == CNT_W'(REFRACTORY - 1)) begin
                        state_nxt = ST_ARMED;
                    end else begin
                        phase_nxt = phase_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (stop && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
        end
    end

    assign push_dat = {push_interval, thr_in, push_timeout, first_q};

    peak_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (evt_valid && evt_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    assign evt_valid = !fifo_empty;
    assign {evt_interval, evt_threshold, evt_timeout, evt_first} = head_dat;
    assign det_rst   = (state == ST_IDLE) || (state == ST_DRST);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule
